// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
   typedef enum logic {OWN_IF, OWN_LS} arb_owner_t;

   localparam int MEM_LAT_MAX = 7;

endpackage

// File: rtl/mem_port_arbiter.sv
// Request/grant/response arbiter sharing one single-port memory between fetch and load/store.
// Define MEM_PORT_ARB_PERF_EN to add saturating per-requester stall counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_be,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_PORT_ARB_PERF_EN
   ,
   output logic [31:0]         if_stall_cnt,
   output logic [31:0]         ls_stall_cnt
`endif
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

   arb_state_t       state_q, state_d;
   arb_owner_t       owner_q, owner_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic             last_ls_q, last_ls_d;

   logic grant_if, grant_ls, grant_read, resp;

   // Grants only in IDLE and never while reset is asserted; ties alternate via last_ls.
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (!rst && state_q == ARB_IDLE) begin
         grant_if = if_req && (!ls_req || last_ls_q);
         grant_ls = ls_req && (!if_req || !last_ls_q);
      end
   end

   assign grant_read = grant_if || (grant_ls && !ls_we);
   assign resp       = !rst && state_q == ARB_WAIT && lat_cnt_q == '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         owner_q   <= OWN_IF;
         lat_cnt_q <= '0;
         last_ls_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         lat_cnt_q <= lat_cnt_d;
         last_ls_q <= last_ls_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      lat_cnt_d = lat_cnt_q;
      last_ls_d = last_ls_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_if || grant_ls) begin
               last_ls_d = grant_ls;
            end
            if (grant_read) begin
               state_d   = ARB_WAIT;
               lat_cnt_d = LAT_INIT;
               owner_d   = grant_ls ? OWN_LS : OWN_IF;
            end
         end
         ARB_WAIT: begin
            if (lat_cnt_q == '0) begin
               state_d = ARB_IDLE;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      if_gnt    = grant_if;
      ls_gnt    = grant_ls;
      mem_en    = grant_if || grant_ls;
      mem_we    = 1'b0;
      mem_addr  = if_addr;
      mem_wdata = '0;
      mem_be    = '1;
      if (grant_ls) begin
         mem_we    = ls_we;
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
         mem_be    = ls_be;
      end
      if_rvalid = resp && owner_q == OWN_IF;
      ls_rvalid = resp && owner_q == OWN_LS;
   end

   assign if_rdata = mem_rdata;
   assign ls_rdata = mem_rdata;

`ifdef MEM_PORT_ARB_PERF_EN
   logic [1:0]  stall_inc;
   logic [31:0] stall_cnt [2];

   assign stall_inc = {ls_req && !ls_gnt, if_req && !if_gnt};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_stall
         logic [31:0] cnt_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
            end else if (stall_inc[gi] && cnt_q != 32'hFFFF_FFFF) begin
               cnt_q <= cnt_q + 32'd1;
            end
         end
         assign stall_cnt[gi] = cnt_q;
      end
   endgenerate

   assign if_stall_cnt = stall_cnt[0];
   assign ls_stall_cnt = stall_cnt[1];
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3), directed scenarios plus a
// randomized run against a cycle-arithmetic reference model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req    [2];
   logic [31:0] if_addr   [2];
   logic        if_gnt    [2];
   logic        if_rvalid [2];
   logic [31:0] if_rdata  [2];
   logic        ls_req    [2];
   logic        ls_we     [2];
   logic [31:0] ls_addr   [2];
   logic [31:0] ls_wdata  [2];
   logic [3:0]  ls_be     [2];
   logic        ls_gnt    [2];
   logic        ls_rvalid [2];
   logic [31:0] ls_rdata  [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [3:0]  mem_be    [2];
   logic [31:0] mem_rdata [2];
`ifdef MEM_PORT_ARB_PERF_EN
   logic [31:0] if_stall_cnt [2];
   logic [31:0] ls_stall_cnt [2];
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1 + 2 * gi)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[gi]), .if_addr(if_addr[gi]), .if_gnt(if_gnt[gi]),
            .if_rvalid(if_rvalid[gi]), .if_rdata(if_rdata[gi]),
            .ls_req(ls_req[gi]), .ls_we(ls_we[gi]), .ls_addr(ls_addr[gi]),
            .ls_wdata(ls_wdata[gi]), .ls_be(ls_be[gi]), .ls_gnt(ls_gnt[gi]),
            .ls_rvalid(ls_rvalid[gi]), .ls_rdata(ls_rdata[gi]),
            .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]), .mem_be(mem_be[gi]), .mem_rdata(mem_rdata[gi])
`ifdef MEM_PORT_ARB_PERF_EN
            , .if_stall_cnt(if_stall_cnt[gi]), .ls_stall_cnt(ls_stall_cnt[gi])
`endif
         );
      end
   endgenerate

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 1'b0; ls_req[k] = 1'b0; ls_we[k] = 1'b0;
         if_addr[k] = '0; ls_addr[k] = '0; ls_wdata[k] = '0; ls_be[k] = '0;
         mem_rdata[k] = '0;
      end
   endtask

   task automatic idle_cycles(input int n);
      idle_all();
      repeat (n) next_cycle();
   endtask

   task automatic do_reset();
      idle_all();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 1'b1; ls_req[k] = 1'b1; ls_we[k] = 1'b1;
         if_addr[k] = 32'h40; ls_addr[k] = 32'h80; ls_be[k] = 4'hF;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({if_gnt[k], ls_gnt[k], if_rvalid[k], ls_rvalid[k], mem_en[k], mem_we[k]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d got %b exp 000000", k,
                     {if_gnt[k], ls_gnt[k], if_rvalid[k], ls_rvalid[k], mem_en[k], mem_we[k]});
         end
      end
      next_cycle();
      rst = 1'b0;
      ls_we[0] = 1'b0; ls_we[1] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({if_gnt[k], ls_gnt[k]} !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_contention dut%0d got %b exp 01", k, {if_gnt[k], ls_gnt[k]});
         end
      end
      next_cycle();
      idle_cycles(5);
      $display("test_reset done");
   endtask

   task automatic test_fetch();
      if_req[0] = 1'b1; if_addr[0] = 32'h10;
      @(negedge clk);
      checks++;
      if ({if_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_be[0], mem_wdata[0]} !==
          {1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0}) begin
         errors++;
         $display("FAIL fetch_grant got gnt=%b en=%b we=%b addr=%h be=%h wd=%h exp 1 1 0 10 f 0",
                  if_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_be[0], mem_wdata[0]);
      end
      next_cycle();
      mem_rdata[0] = 32'hDEADBEEF;
      @(negedge clk);
      checks++;
      if ({if_rvalid[0], if_rdata[0], if_gnt[0], mem_en[0]} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL fetch_resp got rv=%b rd=%h gnt=%b en=%b exp 1 deadbeef 0 0",
                  if_rvalid[0], if_rdata[0], if_gnt[0], mem_en[0]);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (if_gnt[0] !== 1'b1) begin
         errors++;
         $display("FAIL fetch_regrant got %b exp 1", if_gnt[0]);
      end
      next_cycle();
      idle_cycles(3);
      $display("test_fetch done");
   endtask

   task automatic test_contention();
      int ngr = 0;
      do_reset();
      if_req[0] = 1'b1; if_addr[0] = 32'h100;
      ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 32'h104;
      for (int c = 0; c < 20 && ngr < 4; c++) begin
         @(negedge clk);
         if (if_gnt[0] || ls_gnt[0]) begin
            checks++;
            if ({if_gnt[0], ls_gnt[0]} !== ((ngr % 2 == 0) ? 2'b01 : 2'b10)) begin
               errors++;
               $display("FAIL contention_order grant%0d got %b exp %b", ngr,
                        {if_gnt[0], ls_gnt[0]}, (ngr % 2 == 0) ? 2'b01 : 2'b10);
            end
            ngr++;
         end
         next_cycle();
      end
      checks++;
      if (ngr < 4) begin
         errors++;
         $display("FAIL contention_timeout got %0d grants exp 4", ngr);
      end
      idle_cycles(3);
      $display("test_contention done");
   endtask

   task automatic test_store();
      ls_req[0] = 1'b1; ls_we[0] = 1'b1; ls_addr[0] = 32'h200;
      ls_wdata[0] = 32'hA5A5A5A5; ls_be[0] = 4'b0011;
      @(negedge clk);
      checks++;
      if ({ls_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], mem_be[0]} !==
          {1'b1, 1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 4'b0011}) begin
         errors++;
         $display("FAIL store_grant got gnt=%b en=%b we=%b addr=%h wd=%h be=%b exp 1 1 1 200 a5a5a5a5 0011",
                  ls_gnt[0], mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], mem_be[0]);
      end
      next_cycle();
      ls_req[0] = 1'b0; if_req[0] = 1'b1; if_addr[0] = 32'h44;
      @(negedge clk);
      checks++;
      if ({if_gnt[0], ls_rvalid[0], mem_we[0], mem_be[0]} !== {1'b1, 1'b0, 1'b0, 4'hF}) begin
         errors++;
         $display("FAIL store_then_fetch got gnt=%b lsrv=%b we=%b be=%h exp 1 0 0 f",
                  if_gnt[0], ls_rvalid[0], mem_we[0], mem_be[0]);
      end
      next_cycle();
      if_req[0] = 1'b0;
      @(negedge clk);
      checks++;
      if ({if_rvalid[0], ls_rvalid[0]} !== 2'b10) begin
         errors++;
         $display("FAIL store_no_rvalid got %b exp 10", {if_rvalid[0], ls_rvalid[0]});
      end
      next_cycle();
      idle_cycles(2);
      $display("test_store done");
   endtask

   task automatic test_lat3();
      ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h300;
      @(negedge clk);
      checks++;
      if (ls_gnt[1] !== 1'b1) begin
         errors++;
         $display("FAIL lat3_grant got %b exp 1", ls_gnt[1]);
      end
      next_cycle();
      ls_req[1] = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         if_req[1] = 1'b1; if_addr[1] = 32'h50;
         mem_rdata[1] = 32'hC0FFEE00 + i;
         @(negedge clk);
         checks++;
         if ({ls_rvalid[1], if_gnt[1]} !== {(i == 3), 1'b0}) begin
            errors++;
            $display("FAIL lat3_wait cycle%0d got rv=%b gnt=%b exp %b 0", i, ls_rvalid[1], if_gnt[1], (i == 3));
         end
         if (i == 3) begin
            checks++;
            if (ls_rdata[1] !== 32'hC0FFEE03) begin
               errors++;
               $display("FAIL lat3_rdata got %h exp c0ffee03", ls_rdata[1]);
            end
         end
         next_cycle();
      end
      @(negedge clk);
      checks++;
      if (if_gnt[1] !== 1'b1) begin
         errors++;
         $display("FAIL lat3_if_after_rvalid got %b exp 1", if_gnt[1]);
      end
      next_cycle();
      idle_cycles(5);
      $display("test_lat3 done");
   endtask

   task automatic test_reset_mid_wait();
      ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h380;
      @(negedge clk);
      checks++;
      if (ls_gnt[1] !== 1'b1) begin
         errors++;
         $display("FAIL midrst_grant got %b exp 1", ls_gnt[1]);
      end
      next_cycle();
      ls_req[1] = 1'b0; if_req[1] = 1'b1; if_addr[1] = 32'h60; rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({if_gnt[1], ls_gnt[1], if_rvalid[1], ls_rvalid[1], mem_en[1], mem_we[1]} !== 6'b0) begin
         errors++;
         $display("FAIL midrst_outputs got %b exp 000000",
                  {if_gnt[1], ls_gnt[1], if_rvalid[1], ls_rvalid[1], mem_en[1], mem_we[1]});
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({if_gnt[1], ls_rvalid[1]} !== 2'b10) begin
         errors++;
         $display("FAIL midrst_regrant got gnt=%b lsrv=%b exp 1 0", if_gnt[1], ls_rvalid[1]);
      end
      next_cycle();
      if_req[1] = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++;
         if ({if_rvalid[1], ls_rvalid[1]} !== {(i == 3), 1'b0}) begin
            errors++;
            $display("FAIL midrst_resp cycle%0d got %b exp %b0", i, {if_rvalid[1], ls_rvalid[1]}, (i == 3));
         end
         next_cycle();
      end
      idle_cycles(2);
      $display("test_reset_mid_wait done");
   endtask

`ifdef MEM_PORT_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      @(negedge clk);
      checks++;
      if ({if_stall_cnt[0], ls_stall_cnt[0]} !== 64'd0) begin
         errors++;
         $display("FAIL perf_reset got %0d %0d exp 0 0", if_stall_cnt[0], ls_stall_cnt[0]);
      end
      next_cycle();
      if_req[0] = 1'b1; if_addr[0] = 32'h8; ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 32'hC;
      repeat (4) next_cycle();
      idle_all();
      @(negedge clk);
      checks++;
      if ({if_stall_cnt[0], ls_stall_cnt[0]} !== {32'd3, 32'd3}) begin
         errors++;
         $display("FAIL perf_contention got %0d %0d exp 3 3", if_stall_cnt[0], ls_stall_cnt[0]);
      end
      next_cycle();
      idle_cycles(2);
      $display("test_perf done");
   endtask
`endif

   // Model: a read granted at t returns at t+lat and the port frees at t+lat+1; a store frees at t+1.
   task automatic test_random(input int k, input int ncyc);
      int lat = 1 + 2 * k;
      int free_at = 0;
      int resp_at = -1;
      bit resp_ls = 1'b0;
      bit last_ls = 1'b0;
      bit eg_if, eg_ls, ev_if, ev_ls;
      int if_st = 0;
      int ls_st = 0;
      logic [68:0] exp_cmd;
      do_reset();
      for (int t = 0; t < ncyc; t++) begin
         if (!if_req[k] && $urandom_range(0, 2) == 0) begin
            if_req[k] = 1'b1; if_addr[k] = $urandom;
         end else if (if_req[k] && $urandom_range(0, 15) == 0) begin
            if_req[k] = 1'b0;
         end
         if (!ls_req[k] && $urandom_range(0, 2) == 0) begin
            ls_req[k] = 1'b1; ls_we[k] = 1'($urandom_range(0, 1)); ls_addr[k] = $urandom;
            ls_wdata[k] = $urandom; ls_be[k] = 4'($urandom);
         end else if (ls_req[k] && $urandom_range(0, 15) == 0) begin
            ls_req[k] = 1'b0;
         end
         mem_rdata[k] = $urandom;
         @(negedge clk);
         eg_if = 1'b0; eg_ls = 1'b0;
         if (t >= free_at) begin
            if (if_req[k] && ls_req[k]) begin
               eg_if = last_ls; eg_ls = !last_ls;
            end else begin
               eg_if = if_req[k]; eg_ls = ls_req[k];
            end
         end
         ev_if = (t == resp_at) && !resp_ls;
         ev_ls = (t == resp_at) && resp_ls;
         checks++;
         if ({if_gnt[k], ls_gnt[k], mem_en[k]} !== {eg_if, eg_ls, eg_if | eg_ls}) begin
            errors++;
            $display("FAIL rand_gnt dut%0d t=%0d got %b exp %b", k, t,
                     {if_gnt[k], ls_gnt[k], mem_en[k]}, {eg_if, eg_ls, eg_if | eg_ls});
         end
         checks++;
         if ({if_rvalid[k], ls_rvalid[k]} !== {ev_if, ev_ls}) begin
            errors++;
            $display("FAIL rand_rvalid dut%0d t=%0d got %b exp %b", k, t,
                     {if_rvalid[k], ls_rvalid[k]}, {ev_if, ev_ls});
         end
         if (ev_if || ev_ls) begin
            checks++;
            if ((ev_if ? if_rdata[k] : ls_rdata[k]) !== mem_rdata[k]) begin
               errors++;
               $display("FAIL rand_rdata dut%0d t=%0d got %h exp %h", k, t,
                        ev_if ? if_rdata[k] : ls_rdata[k], mem_rdata[k]);
            end
         end
         if (eg_if || eg_ls) begin
            exp_cmd = eg_ls ? {ls_we[k], ls_addr[k], ls_wdata[k], ls_be[k]}
                            : {1'b0, if_addr[k], 32'h0, 4'hF};
            checks++;
            if ({mem_we[k], mem_addr[k], mem_wdata[k], mem_be[k]} !== exp_cmd) begin
               errors++;
               $display("FAIL rand_cmd dut%0d t=%0d got %h exp %h", k, t,
                        {mem_we[k], mem_addr[k], mem_wdata[k], mem_be[k]}, exp_cmd);
            end
            last_ls = eg_ls;
            if (eg_if || !ls_we[k]) begin
               resp_at = t + lat; resp_ls = eg_ls; free_at = t + lat + 1;
            end else begin
               free_at = t + 1;
            end
         end
         if (if_req[k] && !eg_if) if_st++;
         if (ls_req[k] && !eg_ls) ls_st++;
         next_cycle();
         if (eg_if) if_req[k] = 1'b0;
         if (eg_ls) ls_req[k] = 1'b0;
      end
      idle_all();
      @(negedge clk);
`ifdef MEM_PORT_ARB_PERF_EN
      checks++;
      if ({if_stall_cnt[k], ls_stall_cnt[k]} !== {32'(if_st), 32'(ls_st)}) begin
         errors++;
         $display("FAIL rand_stall dut%0d got %0d %0d exp %0d %0d", k,
                  if_stall_cnt[k], ls_stall_cnt[k], if_st, ls_st);
      end
`endif
      next_cycle();
      idle_cycles(5);
      $display("test_random dut%0d done (if stalls %0d, ls stalls %0d)", k, if_st, ls_st);
   endtask

   initial begin
      rst = 1'b1;
      idle_all();
      repeat (2) next_cycle();
      test_reset();
      test_fetch();
      test_contention();
      test_store();
      test_lat3();
      test_reset_mid_wait();
`ifdef MEM_PORT_ARB_PERF_EN
      test_perf();
`endif
      test_random(0, 400);
      test_random(1, 400);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
